// File: rtl/popcnt_accum_if.sv
// ----------------------------------------------------------------------------
// popcnt_accum_if
//
// Purpose:
//   Bundles the two valid/ready ports of the popcnt_accum frame statistics
//   unit. The word stream enters on the in_* side. The per-frame result
//   leaves on the out_* side.
//
// Signals:
//   in_valid   in_word/in_last are valid (producer -> unit)
//   in_ready   unit can accept a word (unit -> producer)
//   in_word    32-bit data word to count
//   in_last    word closes the current frame
//   out_valid  frame result is valid (unit -> consumer)
//   out_ready  consumer takes the result (consumer -> unit)
//   out_sum    total set bits in the frame, saturating, ACC_W bits
//   out_words  number of words in the frame
//   out_max    largest per-word count in the frame (0..32)
//   out_ovf    sum saturated during the frame
//
// Modports:
//   master  environment side: drives the word stream and out_ready
//   slave   popcnt_accum side: drives in_ready and the result
// ----------------------------------------------------------------------------
interface popcnt_accum_if #(
    parameter int ACC_W = 12
) ();

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_word;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_words;
    logic [5:0]       out_max;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_word,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_words,
        input  out_max,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_words,
        output out_max,
        output out_ovf
    );

endinterface

// File: rtl/popcnt_accum.sv
// ----------------------------------------------------------------------------
// popcnt_accum
//
// Purpose:
//   Frame statistics unit. It takes a stream of 32-bit words over
//   valid/ready. For each frame it accumulates three values:
//     - the total number of set bits, saturating at 2^ACC_W-1, with a
//       sticky overflow flag;
//     - the number of words in the frame;
//     - the largest per-word set-bit count.
//   The finished result is presented over a second valid/ready port.
//
//   Pipeline:
//     stage 1  registers popcount(in_word) on every accept
//     stage 2  folds the registered count into the frame accumulators
//
//   The FSM has three states:
//     RUN    accepting words
//     DRAIN  one cycle in which stage 2 absorbs the final word
//     HOLD   result is valid and waits for out_ready
//
// Parameters:
//   ACC_W      width of the set-bit sum accumulator (saturating)
//   MAX_WORDS  frame length limit, 1..255; the MAX_WORDS-th word closes
//              the frame even without in_last
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous, active-low reset
//   bus      popcnt_accum_if.slave (word stream in, frame result out)
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// popcnt32
//
// Purpose:
//   Combinational 32-bit ones counter built as a balanced adder tree.
//
// Ports:
//   word   32-bit input word
//   count  number of set bits in word (0..32)
// ----------------------------------------------------------------------------
module popcnt32 (
    input  logic [31:0] word,
    output logic [5:0]  count
);

    logic [1:0] lvl1 [16];
    logic [2:0] lvl2 [8];
    logic [3:0] lvl3 [4];
    logic [4:0] lvl4 [2];

    // Pairwise adder tree. Each level widens by one bit, which is exactly
    // enough to hold the largest sum of its two children.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            lvl1[i] = {1'b0, word[2*i]} + {1'b0, word[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
        end
        count = {1'b0, lvl4[0]} + {1'b0, lvl4[1]};
    end

endmodule

module popcnt_accum #(
    parameter int ACC_W     = 12,
    parameter int MAX_WORDS = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    popcnt_accum_if.slave  bus
);

    localparam int         SUM_EXT_W = ACC_W + 1;
    localparam logic [8:0] MAX_W9    = 9'(MAX_WORDS);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             release_res;
    logic             eff_last;
    logic             in_ready_c;
    logic             out_valid_c;

    logic [5:0]       pc_cnt;
    logic [5:0]       pc_q;
    logic             pc_v;
    logic             pc_last;
    logic [7:0]       words_acc;

    logic [ACC_W-1:0] sum;
    logic [7:0]       words;
    logic [5:0]       max;
    logic             ovf;

    logic [SUM_EXT_W-1:0] sum_ext;
    logic [ACC_W-1:0]     sum_sat;
    logic                 sum_carry;

    popcnt32 u_popcnt (
        .word  (bus.in_word),
        .count (pc_cnt)
    );

    // Handshake qualifiers and frame-close detection.
    // words_acc counts accepts, so it already knows about the current word
    // one cycle before stage 2 does. That lets the frame limit close the
    // frame on the same edge that accepts the limiting word. The compare is
    // done in 9 bits so that words_acc+1 cannot wrap at 255.
    always_comb begin
        in_ready_c  = (state == RUN);
        out_valid_c = (state == HOLD);
        accept      = bus.in_valid & in_ready_c;
        release_res = out_valid_c & bus.out_ready;
        eff_last    = bus.in_last | (({1'b0, words_acc} + 9'd1) == MAX_W9);
    end

    // Next-state logic. DRAIN always lasts exactly one cycle: the final
    // word's count sits in stage 1 and is folded in on the DRAIN edge, so
    // the accumulators are complete by the time HOLD begins.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (accept && eff_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating add for the stage 2 sum. The extra top bit of sum_ext is
    // the carry out of the accumulator width. It is set exactly when the
    // true sum exceeds 2^ACC_W-1, so it also serves as the overflow event.
    always_comb begin
        sum_ext   = {1'b0, sum} + SUM_EXT_W'(pc_q);
        sum_carry = sum_ext[ACC_W];
        sum_sat   = sum_carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    end

    // Stage 1: capture the per-word count on every accept. pc_v is a
    // one-cycle strobe, so idle cycles and stalled cycles leave stage 2
    // untouched. words_acc tracks accepted words for the frame-length limit
    // and is cleared together with the result when the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= '0;
            pc_v      <= 1'b0;
            pc_last   <= 1'b0;
            words_acc <= '0;
        end else begin
            if (accept) begin
                pc_q      <= pc_cnt;
                pc_v      <= 1'b1;
                pc_last   <= eff_last;
                words_acc <= words_acc + 8'd1;
            end else begin
                pc_v <= 1'b0;
                if (release_res) begin
                    words_acc <= '0;
                end
            end
        end
    end

    // Stage 2: frame accumulators.
    // The release edge (HOLD with out_ready) clears them for the next frame.
    // A release and a valid stage 1 count never coincide: stage 1 only
    // fills in RUN, and it has drained by the time HOLD is reached. The
    // overflow flag is sticky until release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum   <= '0;
            words <= '0;
            max   <= '0;
            ovf   <= 1'b0;
        end else if (release_res) begin
            sum   <= '0;
            words <= '0;
            max   <= '0;
            ovf   <= 1'b0;
        end else if (pc_v) begin
            sum   <= sum_sat;
            words <= words + 8'd1;
            if (pc_q > max) begin
                max <= pc_q;
            end
            if (sum_carry) begin
                ovf <= 1'b1;
            end
        end
    end

    // Output drive. The result comes straight from the accumulator
    // registers. Partial values are visible in RUN/DRAIN; consumers should
    // only look at them while out_valid is high.
    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.out_valid = out_valid_c;
        bus.out_sum   = sum;
        bus.out_words = words;
        bus.out_max   = max;
        bus.out_ovf   = ovf;
    end

`ifndef SYNTHESIS
    // DRAIN is only ever entered through the accept of a closing word, so
    // stage 1 must be holding that word's count, marked as last.
    assert property (@(posedge clk) disable iff (!reset_n)
        (state == DRAIN) |-> (pc_v && pc_last));
`endif

endmodule

// File: tb/tb_popcnt_accum.sv
// ----------------------------------------------------------------------------
// tb_popcnt_accum
//
// Purpose:
//   Directed bench for popcnt_accum. It instantiates two copies of the unit:
//     dutA  default parameters (ACC_W=12, MAX_WORDS=255)
//     dutB  MAX_WORDS=3, used for the frame-length limit
//   Expected values are hand-computed constants.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_popcnt_accum;

    logic clk;
    logic reset_n;

    int compared;
    int mismatched;

    popcnt_accum_if #(.ACC_W(12)) bifA ();
    popcnt_accum_if #(.ACC_W(12)) bifB ();

    popcnt_accum #(.ACC_W(12), .MAX_WORDS(255)) dutA (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bifA)
    );

    popcnt_accum #(.ACC_W(12), .MAX_WORDS(3)) dutB (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bifB)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the sequence below ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Presents one word on dutA and returns #1 after the edge that accepted
    // it. It is always entered #1 after a rising edge. The wait for in_ready
    // is bounded.
    task automatic applyStimulus(input logic [31:0] w, input logic l);
        int waitCycles;
        waitCycles     = 0;
        bifA.in_valid  = 1'b1;
        bifA.in_word   = w;
        bifA.in_last   = l;
        while (!bifA.in_ready && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!bifA.in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        bifA.in_valid = 1'b0;
        bifA.in_last  = 1'b0;
    endtask

    // Entered #1 after the edge that accepted the closing word on dutA,
    // with out_ready=1. It checks:
    //   - the latency of out_valid;
    //   - the frame result;
    //   - that in_ready drops for exactly two cycles.
    task automatic finishFrame(input string tag, input logic [11:0] expSum,
                               input logic [7:0] expWords,
                               input logic [5:0] expMax,
                               input logic expOvf);
        int lowCycles;
        lowCycles = 0;
        checkOutput({tag, "_valid_early"}, 32'(bifA.out_valid), 32'd0);
        if (!bifA.in_ready) lowCycles++;
        @(posedge clk); #1;
        checkOutput({tag, "_valid"}, 32'(bifA.out_valid), 32'd1);
        checkOutput({tag, "_sum"},   32'(bifA.out_sum),   32'(expSum));
        checkOutput({tag, "_words"}, 32'(bifA.out_words), 32'(expWords));
        checkOutput({tag, "_max"},   32'(bifA.out_max),   32'(expMax));
        checkOutput({tag, "_ovf"},   32'(bifA.out_ovf),   32'(expOvf));
        if (!bifA.in_ready) lowCycles++;
        @(posedge clk); #1;
        checkOutput({tag, "_ready_back"}, 32'(bifA.in_ready), 32'd1);
        checkOutput({tag, "_gap"}, 32'(lowCycles), 32'd2);
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        reset_n        = 1'b0;
        bifA.in_valid  = 1'b0;
        bifA.in_word   = '0;
        bifA.in_last   = 1'b0;
        bifA.out_ready = 1'b1;
        bifB.in_valid  = 1'b0;
        bifB.in_word   = '0;
        bifB.in_last   = 1'b0;
        bifB.out_ready = 1'b1;

        // Reset state.
        #2;
        checkOutput("rst_in_ready",  32'(bifA.in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(bifA.out_valid), 32'd0);
        checkOutput("rst_result", {bifA.out_sum, bifA.out_words, bifA.out_max,
                                   bifA.out_ovf}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single full word");
        applyStimulus(32'hFFFF_FFFF, 1'b1);
        finishFrame("t1", 12'd32, 8'd1, 6'd32, 1'b0);

        $display("[TB] four-word back-to-back frame");
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'hFFFF_EFFF, 1'b0);
        applyStimulus(32'hFFFF_FF00, 1'b0);
        applyStimulus(32'hFF00_0000, 1'b1);
        finishFrame("t2", 12'd95, 8'd4, 6'd32, 1'b0);

        $display("[TB] consumer stall in HOLD");
        bifA.out_ready = 1'b0;
        applyStimulus(32'h0000_0000, 1'b0);
        applyStimulus(32'h0000_0001, 1'b1);
        bifA.in_valid = 1'b1;
        bifA.in_word  = 32'hFFFF_FFFF;
        bifA.in_last  = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_ctrl", {bifA.out_valid, bifA.in_ready,
                                      bifA.out_ovf}, 32'b100);
            checkOutput("hold_data", {bifA.out_sum, bifA.out_words,
                                      bifA.out_max}, {12'd1, 8'd2, 6'd1});
            @(posedge clk); #1;
        end
        bifA.in_valid  = 1'b0;
        bifA.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("hold_release", {bifA.out_valid, bifA.in_ready}, 32'b01);

        $display("[TB] saturating 128-word frame");
        for (int i = 0; i < 128; i++) begin
            applyStimulus(32'hFFFF_FFFF, (i == 127));
        end
        finishFrame("t4sat", 12'd4095, 8'd128, 6'd32, 1'b1);
        applyStimulus(32'h0000_000F, 1'b1);
        finishFrame("t4next", 12'd4, 8'd1, 6'd4, 1'b0);

        $display("[TB] frame length limit on MAX_WORDS=3 instance");
        bifB.in_valid = 1'b1;
        bifB.in_word  = 32'h0000_0003;
        bifB.in_last  = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("lim_drain", {bifB.in_ready, bifB.out_valid}, 32'b00);
        @(posedge clk); #1;
        checkOutput("lim_valid", 32'(bifB.out_valid), 32'd1);
        checkOutput("lim_data", {bifB.out_sum, bifB.out_words, bifB.out_max,
                                 bifB.out_ovf}, {12'd6, 8'd3, 6'd2, 1'b0});
        @(posedge clk); #1;
        checkOutput("lim_run", {bifB.in_ready, bifB.out_valid}, 32'b10);
        bifB.in_last = 1'b1;
        @(posedge clk); #1;
        bifB.in_valid = 1'b0;
        bifB.in_last  = 1'b0;
        @(posedge clk); #1;
        checkOutput("lim_next", {bifB.out_valid, bifB.out_sum, bifB.out_words,
                                 bifB.out_max}, {1'b1, 12'd2, 8'd1, 6'd2});
        @(posedge clk); #1;

        $display("[TB] reset in mid-frame");
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        reset_n = 1'b0;
        #2;
        checkOutput("mid_rst_out", {bifA.out_valid, bifA.out_sum,
                                    bifA.out_words, bifA.out_max,
                                    bifA.out_ovf}, 32'd0);
        checkOutput("mid_rst_ready", 32'(bifA.in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'h0000_00FF, 1'b1);
        finishFrame("t6", 12'd8, 8'd1, 6'd8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/popcnt_accum.md
Name: popcnt_accum

Overview:
- Multi-cycle frame statistics unit that sits directly downstream of the team's 32-bit combinational ones-counter (32-bit in, 6-bit out).
- The counter is instantiated internally.
- Accepts a stream of 32-bit words over valid/ready.
- Per frame, accumulates the total set-bit count, the word count and the maximum per-word count, then presents the result over a second valid/ready port.

Parameters:
- ACC_W, 12, width of the set-bit sum accumulator; saturates at 2^ACC_W-1.
- MAX_WORDS, 255, frame length limit; the MAX_WORDS-th accepted word is treated as last (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_word/in_last are valid.
- in_ready  out  1  block can accept a word.
- in_word  in  32  data word to count.
- in_last  in  1  word closes the current frame.
- out_valid  out  1  frame result is valid.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_W  total set bits in the frame (saturating).
- out_words  out  8  number of words in the frame.
- out_max  out  6  largest per-word count in the frame (0..32).
- out_ovf  out  1  sum saturated during the frame.

Behaviour:
- Reset (async, reset_n=0):
  - state=RUN; pc_q=0, pc_v=0, pc_last=0.
  - sum=0, words=0, max=0, ovf=0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_words=0, out_max=0, out_ovf=0.
- States: RUN, DRAIN, HOLD. in_ready = (state==RUN); out_valid = (state==HOLD). Both are combinational from state only.
- Accept = in_valid & in_ready.
- Stage 1, on an accept edge:
  - pc_q <= popcount(in_word); pc_v <= 1.
  - pc_last <= in_last | (words_acc+1 == MAX_WORDS).
  - words_acc is a separate accept counter, incremented on accept.
- Stage 1, otherwise: pc_v <= 0.
- Stage 2, on an edge with pc_v=1:
  - sum <= min(sum+pc_q, 2^ACC_W-1). If the unsaturated sum exceeds the limit, ovf <= 1 (sticky for the frame).
  - words <= words+1.
  - max <= max(max, pc_q).
- Transitions:
  - RUN -> DRAIN on an accept whose effective last is true (in_last or MAX_WORDS reached).
  - DRAIN -> HOLD unconditionally after one cycle; stage 2 absorbs the final word on this edge.
  - HOLD -> RUN on out_ready=1. On that edge clear sum, words, max, ovf and words_acc.
  - HOLD with out_ready=0: hold all outputs stable indefinitely; in_ready stays 0.
- Latency: out_valid rises 2 clock edges after the edge accepting the last word.
- Throughput: 1 word/cycle in RUN. Minimum frame-to-frame gap: 2 cycles (DRAIN+HOLD) when out_ready=1.
- out_* are driven from registers sum/words/max/ovf. In RUN/DRAIN they show partial values, but they are only meaningful when out_valid=1.
- Zero-bit words count toward words and contribute 0 to sum.
- in_last with in_valid=0 is ignored. Input is not sampled while in_ready=0.
- A frame is ≥1 word. An empty frame cannot be signalled.
- Reset mid-frame or in HOLD discards all partial results. The first post-reset accept starts a fresh frame.

Test Plan:
- Single word 0xFFFFFFFF with in_last=1 -> out_valid high 2 edges after accept; sum=32, words=1, max=32, ovf=0.
- Frame 0xFFFFFFFF, 0xFFFFEFFF, 0xFFFFFF00, 0xFF000000 (last on the 4th), back-to-back -> sum=95, words=4, max=32, ovf=0. in_ready is low for exactly 2 cycles when out_ready=1.
- out_ready held low for 10 cycles after the frame 0x00000000, 0x00000001 (last) -> sum=1, words=2, max=1, stable all 10 cycles. in_ready=0 throughout; offered words are not consumed.
- 128 words of 0xFFFFFFFF, last on the 128th, ACC_W=12 -> sum=4095, ovf=1, words=128, max=32. The next frame 0x0000000F (last) gives sum=4, ovf=0.
- MAX_WORDS=3, stream of 0x00000003 with in_last=0 -> result after the 3rd word: sum=6, words=3, max=2. The 4th word starts a new frame.
- Pulse reset_n low after 2 words of 0xFFFFFFFF, then send 0x000000FF (last) -> sum=8, words=1, max=8, ovf=0. All outputs are 0 while reset_n=0.
